// File: rtl/spi_regfile_ctrlr.sv
// spi_regfile_ctrlr: SPI byte-protocol register file with chip id, scratch, switch and LED registers plus burst access
module spi_regfile_ctrlr #(
  parameter int SW_W = 16,
  parameter int LED_W = 16,
  parameter int ADDR_W = 4,
  parameter logic [7:0] CHIP_ID = 8'h17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame,
  input  logic             new_data,
  input  logic [7:0]       din,
  output logic [7:0]       dout,
  input  logic [SW_W-1:0]  switches,
  output logic [LED_W-1:0] leds,
  output logic             bad_acc
);
  localparam int NSW = SW_W / 8;
  localparam int NLED = LED_W / 8;
  typedef enum logic [1:0] {ST_CMD, ST_READ, ST_WRITE} state_t;
  state_t state;
  logic [ADDR_W-1:0] addr;
  logic ai;
  logic [7:0] scratch;
  logic [7:0] rdata;
  logic mapped;
  logic writable;
  // read mux over the register map; unmapped addresses read as all ones
  always_comb begin
    rdata = 8'hFF;
    if (int'(addr) == 0) rdata = CHIP_ID;
    if (int'(addr) == 1) rdata = scratch;
    for (int k = 0; k < NSW; k++) if (int'(addr) == 2 + k) rdata = switches[8*k +: 8];
    for (int j = 0; j < NLED; j++) if (int'(addr) == 2 + NSW + j) rdata = leds[8*j +: 8];
    mapped = int'(addr) < 2 + NSW + NLED;
    writable = int'(addr) == 1 || (mapped && int'(addr) >= 2 + NSW);
  end
  // command decode, burst read/write and sticky error flag; dropping frame aborts everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_CMD;
      addr <= '0;
      ai <= 1'b0;
      dout <= 8'h00;
      leds <= '0;
      scratch <= 8'h00;
      bad_acc <= 1'b0;
    end else if (!frame) begin
      state <= ST_CMD;
    end else begin
      case (state)
        ST_CMD: if (new_data) begin
          addr <= din[ADDR_W-1:0];
          ai <= din[6];
          state <= din[7] ? ST_READ : ST_WRITE;
        end
        ST_READ: begin
          dout <= rdata;
          if (!mapped) bad_acc <= 1'b1;
          if (new_data && ai) addr <= addr + 1'b1;
        end
        ST_WRITE: if (new_data) begin
          if (int'(addr) == 1) scratch <= din;
          for (int j = 0; j < NLED; j++) if (int'(addr) == 2 + NSW + j) leds[8*j +: 8] <= din;
          if (!writable) bad_acc <= 1'b1;
          if (ai) addr <= addr + 1'b1;
        end
        default: state <= ST_CMD;
      endcase
    end
  end
endmodule
